// File: rtl/mul7_sched.sv
// mul7_sched: two-requester scheduler in front of a shared 7*a*b datapath.
// A four-state FSM (IDLE -> MUL -> SCALE -> DONE) serves one request at a time.
// The multiply by 7 is done as (p << 3) - p on the registered product.
// Optional feature: define MUL7_SCHED_ROUND_ROBIN_EN for round-robin arbitration
// on ties; without it req0 always wins a tie.
module mul7_sched #(
  parameter int WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [2*WIDTH+2:0]   result,
  output logic                 grant,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = 2 * WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [PW-1:0]     p_reg;
  logic [RW-1:0]     result_reg;
  logic              grant_reg;
  logic              busy_reg;
  logic [1:0]        ack_reg;

  logic              win_next;
  logic [WIDTH-1:0]  a_next;
  logic [WIDTH-1:0]  b_next;
  logic [PW-1:0]     p_next;
  logic [RW-1:0]     scaled_next;
  logic [1:0]        ack_next;

`ifdef MUL7_SCHED_ROUND_ROBIN_EN
  // Index of the requester granted most recently; resets to 1 so requester 0
  // wins the first tie.
  logic              last_reg;

  // Round-robin: on a tie favour whoever was not served last.
  always_comb begin
    win_next = req1;
    if (req0 && req1) begin
      win_next = ~last_reg;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    win_next = ~req0 & req1;
  end
`endif

  // Operand mux for the winning requester, only consumed on the grant edge.
  assign a_next = win_next ? a1 : a0;
  assign b_next = win_next ? b1 : b0;

  // Full-width product and the times-seven scaling; the extra three result
  // bits absorb the shift so nothing is truncated.
  assign p_next      = a_reg * b_reg;
  assign scaled_next = {p_reg, 3'b000} - {3'b000, p_reg};

  // One-hot ack decode from the served requester.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_next[gi] = (grant_reg == 1'(gi));
    end
  endgenerate

  // Scheduler FSM with all outputs registered; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      p_reg      <= '0;
      result_reg <= '0;
      grant_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      ack_reg    <= 2'b00;
`ifdef MUL7_SCHED_ROUND_ROBIN_EN
      last_reg   <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= 2'b00;
          if (req0 || req1) begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            grant_reg <= win_next;
            busy_reg  <= 1'b1;
            state_reg <= MUL;
`ifdef MUL7_SCHED_ROUND_ROBIN_EN
            last_reg  <= win_next;
`endif
          end
        end
        MUL: begin
          p_reg     <= p_next;
          state_reg <= SCALE;
        end
        SCALE: begin
          result_reg <= scaled_next;
          ack_reg    <= ack_next;
          state_reg  <= DONE;
        end
        DONE: begin
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ack0   = ack_reg[0];
  assign ack1   = ack_reg[1];
  assign result = result_reg;
  assign grant  = grant_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_mul7_sched.sv
// tb_mul7_sched: directed bench with a scoreboard of expected completions.
module tb_mul7_sched;

  localparam int W  = 20;
  localparam int RW = 2 * W + 3;

  logic          clk;
  logic          rst;
  logic          req0;
  logic          req1;
  logic [W-1:0]  a0;
  logic [W-1:0]  b0;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic          ack0;
  logic          ack1;
  logic [RW-1:0] result;
  logic          grant;
  logic          busy;

  typedef struct {
    bit            idx;
    logic [RW-1:0] res;
  } exp_t;

  exp_t          sb[$];
  int            compared   = 0;
  int            mismatched = 0;
  logic [RW-1:0] last_res;

  mul7_sched #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .ack0   (ack0),
    .ack1   (ack1),
    .result (result),
    .grant  (grant),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b) * 64'd7;
    return full[RW-1:0];
  endfunction

  task automatic push(input bit idx, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.idx = idx;
    e.res = model(a, b);
    sb.push_back(e);
  endtask

  // Called in a cycle where an ack is visible: compare against the oldest entry.
  task automatic pop_check(input string tag);
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("FAIL %s_sb: observed ack with %0d queued expected at least 1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_ack"}, 64'({ack1, ack0}), e.idx ? 64'd2 : 64'd1);
      check({tag, "_res"}, 64'(result), 64'(e.res));
      check({tag, "_grant"}, 64'(grant), 64'(e.idx));
      last_res = e.res;
    end
  endtask

  // Bounded wait for any ack, then scoreboard comparison.
  task automatic wait_ack(input string tag);
    int n = 0;
    while (!(ack0 || ack1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    assert (n < 20) else begin
      mismatched++;
      $error("FAIL %s_timeout: observed %0d cycles without ack expected < 20", tag, n);
    end
    if (ack0 || ack1) pop_check(tag);
  endtask

  // One isolated operation with exact latency checks; optional operand change
  // right after the grant edge.
  task automatic single_op(input bit idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit perturb, input string tag);
    if (idx == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else             begin req1 = 1'b1; a1 = a; b1 = b; end
    push(idx, a, b);
    @(posedge clk); #1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_grant0"}, 64'(grant), 64'(idx));
    if (perturb) begin
      a0 = ~a; b0 = b + W'(1);
      a1 = ~a; b1 = b + W'(1);
    end
    @(posedge clk); #1;
    check({tag, "_noack"}, 64'({ack1, ack0}), 64'd0);
    @(posedge clk); #1;
    pop_check(tag);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_ackend"}, 64'({ack1, ack0}), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_hold"}, 64'(result), 64'(last_res));
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_ack", 64'({ack1, ack0}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);

    single_op(1'b0, W'(1), W'(2), 1'b0, "op14");
    single_op(1'b1, W'(2), W'(3), 1'b0, "op42");
    single_op(1'b1, W'(6), W'(8), 1'b0, "op336");
    single_op(1'b0, {W{1'b1}}, {W{1'b1}}, 1'b0, "opmax");
    single_op(1'b0, W'(5), W'(9), 1'b1, "opperturb");

    // Reset while the operation sits in SCALE.
    req0 = 1'b1; a0 = W'(3); b0 = W'(4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_noack", 64'({ack1, ack0}), 64'd0);
      @(posedge clk); #1;
    end
    single_op(1'b0, W'(6), W'(8), 1'b0, "post_rst");
    single_op(1'b1, W'(0), W'(12345), 1'b0, "opzero");

    // Both requesters asking together, held across operations.
    a0 = W'(1); b0 = W'(2); a1 = W'(2); b1 = W'(3);
    req0 = 1'b1; req1 = 1'b1;
`ifdef MUL7_SCHED_ROUND_ROBIN_EN
    push(1'b0, W'(1), W'(2));
    push(1'b1, W'(2), W'(3));
`else
    push(1'b0, W'(1), W'(2));
    push(1'b0, W'(1), W'(2));
    push(1'b1, W'(2), W'(3));
`endif
    @(posedge clk); #1;
    check("tie_grant_a", 64'(grant), 64'd0);
    check("tie_busy_a", 64'(busy), 64'd1);
    wait_ack("tie_first");
    @(posedge clk); #1;
`ifdef MUL7_SCHED_ROUND_ROBIN_EN
    req0 = 1'b0;
    @(posedge clk); #1;
    check("tie_grant_b", 64'(grant), 64'd1);
    check("tie_busy_b", 64'(busy), 64'd1);
    wait_ack("tie_second");
    @(posedge clk); #1;
    req1 = 1'b0;
`else
    @(posedge clk); #1;
    check("tie_grant_b", 64'(grant), 64'd0);
    check("tie_busy_b", 64'(busy), 64'd1);
    wait_ack("tie_second");
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    check("tie_grant_c", 64'(grant), 64'd1);
    check("tie_busy_c", 64'(busy), 64'd1);
    wait_ack("tie_third");
    @(posedge clk); #1;
    req1 = 1'b0;
`endif
    @(posedge clk); #1;
    check("final_idle", 64'(busy), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
